// File: rtl/riscv_v_pkg.sv
// Shared types and defaults for the scalar-side vector dispatch block.
package riscv_v_pkg;

  localparam int         RISCV_V_DISPATCH_QDEPTH = 4;
  localparam int         RISCV_V_DISPATCH_PDEPTH = 4;
  localparam logic [5:0] RISCV_V_NOP_OPCODE      = 6'd0;

  typedef struct packed {
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] rs1_data;
    logic        is_v2i;
  } v_dispatch_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } v_dispatch_state_t;

endpackage

// File: rtl/riscv_v_dispatch_fifo.sv
// Circular FIFO with wrap-bit pointers, flush, and a per-slot view used for hazard lookups.
module riscv_v_dispatch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0]             rd_data,
  output logic [DEPTH-1:0][WIDTH-1:0]  entries,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [AW:0]                  count,
  output logic                         full,
  output logic                         empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // A slot is live when its distance from the read pointer is below the fill count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [AW-1:0] offset;
    assign offset          = AW'(gi) - rd_ptr[AW-1:0];
    assign entries[gi]     = mem[gi];
    assign entry_valid[gi] = ({1'b0, offset} < count);
  end

endmodule

// File: rtl/riscv_v_dispatch.sv
// Scalar-side vector issue/return: instruction queue, pending v2i tracker, fence FSM.
// Optional macro RISCV_V_DISPATCH_BYPASS_EN: empty-queue bypass onto the issue registers.
module riscv_v_dispatch
  import riscv_v_pkg::*;
#(
  parameter int         QDEPTH     = RISCV_V_DISPATCH_QDEPTH,
  parameter int         PDEPTH     = RISCV_V_DISPATCH_PDEPTH,
  parameter logic [5:0] NOP_OPCODE = RISCV_V_NOP_OPCODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_pipe,
  input  logic        sc_v_valid,
  input  logic [31:0] sc_instr,
  input  logic [5:0]  sc_opcode,
  input  logic [31:0] sc_rs1_data,
  input  logic        sc_is_v2i,
  input  logic [4:0]  sc_rd_addr,
  input  logic        sc_fence,
  input  logic [4:0]  sc_rs1_addr,
  input  logic [4:0]  sc_rs2_addr,
  output logic        sc_stall,
  output logic [31:0] instruction_id,
  output logic [5:0]  opcode_id,
  output logic [31:0] int_rf_rd_data_id,
  input  logic        riscv_v_stall,
  input  logic [31:0] int_rf_wr_data_wb,
  input  logic        int_rf_wr_en_wb,
  output logic        sc_rf_wr_en,
  output logic [4:0]  sc_rf_wr_addr,
  output logic [31:0] sc_rf_wr_data
);

  localparam int QAW     = $clog2(QDEPTH);
  localparam int PAW     = $clog2(PDEPTH);
  localparam int ENTRY_W = $bits(v_dispatch_entry_t);

  v_dispatch_state_t state, state_next;
  v_dispatch_entry_t in_entry, q_head, issue_entry;

  logic                           q_full, q_empty, q_push, q_pop;
  logic                           p_full, p_empty, p_push, p_pop;
  logic [4:0]                     p_head;
  logic [PDEPTH-1:0][4:0]         p_entries;
  logic [PDEPTH-1:0]              p_valid;
  logic [PDEPTH-1:0]              p_hit;
  logic [PAW:0]                   p_count;
  logic                           enq, bypass, issue_any, hazard, drain_stall;
  logic [QDEPTH-1:0][ENTRY_W-1:0] q_entries_unused;
  logic [QDEPTH-1:0]              q_valid_unused;
  logic [QAW:0]                   q_count_unused;
  logic                           head_v2i_unused;

  assign in_entry        = '{instr: sc_instr, opcode: sc_opcode, rs1_data: sc_rs1_data, is_v2i: sc_is_v2i};
  assign head_v2i_unused = q_head.is_v2i;

  riscv_v_dispatch_fifo #(.WIDTH(ENTRY_W), .DEPTH(QDEPTH)) u_instr_q (
    .clk(clk), .rst(rst), .flush(clear_pipe), .push(q_push), .pop(q_pop),
    .wr_data(in_entry), .rd_data(q_head), .entries(q_entries_unused),
    .entry_valid(q_valid_unused), .count(q_count_unused), .full(q_full), .empty(q_empty)
  );

  riscv_v_dispatch_fifo #(.WIDTH(5), .DEPTH(PDEPTH)) u_pending_q (
    .clk(clk), .rst(rst), .flush(clear_pipe), .push(p_push), .pop(p_pop),
    .wr_data(sc_rd_addr), .rd_data(p_head), .entries(p_entries),
    .entry_valid(p_valid), .count(p_count), .full(p_full), .empty(p_empty)
  );

  // Any live pending destination (x0 excluded) read by decode is a RAW hazard.
  for (genvar gi = 0; gi < PDEPTH; gi++) begin : g_hazard
    assign p_hit[gi] = p_valid[gi] && (p_entries[gi] != 5'd0) &&
                       ((p_entries[gi] == sc_rs1_addr) || (p_entries[gi] == sc_rs2_addr));
  end
  assign hazard = |p_hit;

  assign sc_stall = q_full | (p_full & sc_is_v2i) | drain_stall | hazard;
  assign enq      = sc_v_valid && !sc_stall && !clear_pipe;

`ifdef RISCV_V_DISPATCH_BYPASS_EN
  assign bypass = enq && q_empty && !riscv_v_stall;
`else
  assign bypass = 1'b0;
`endif

  assign q_push      = enq && !bypass;
  assign q_pop       = !q_empty && !riscv_v_stall && !clear_pipe;
  assign p_push      = enq && sc_is_v2i;
  assign p_pop       = int_rf_wr_en_wb && !p_empty && !clear_pipe;
  assign issue_any   = q_pop || bypass;
  assign issue_entry = bypass ? in_entry : q_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode_id         <= NOP_OPCODE;
      instruction_id    <= '0;
      int_rf_rd_data_id <= '0;
    end else if (clear_pipe) begin
      opcode_id         <= NOP_OPCODE;
      instruction_id    <= '0;
      int_rf_rd_data_id <= '0;
    end else if (!riscv_v_stall) begin
      if (issue_any) begin
        opcode_id         <= issue_entry.opcode;
        instruction_id    <= issue_entry.instr;
        int_rf_rd_data_id <= issue_entry.rs1_data;
      end else begin
        opcode_id         <= NOP_OPCODE;
        instruction_id    <= '0;
        int_rf_rd_data_id <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc_rf_wr_en   <= 1'b0;
      sc_rf_wr_addr <= '0;
      sc_rf_wr_data <= '0;
    end else begin
      sc_rf_wr_en <= p_pop;
      if (p_pop) begin
        sc_rf_wr_addr <= p_head;
        sc_rf_wr_data <= int_rf_wr_data_wb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    drain_stall = 1'b0;
    case (state)
      ST_RUN:   if (sc_fence && !(q_empty && p_empty)) state_next = ST_DRAIN;
      ST_DRAIN: begin
        drain_stall = 1'b1;
        if (q_empty && p_empty) state_next = ST_RUN;
      end
      default:  state_next = ST_RUN;
    endcase
    if (clear_pipe) state_next = ST_RUN;
  end

`ifndef SYNTHESIS
  // Results of v2i work dropped by clear_pipe may still trickle back; tolerate that many.
  logic [15:0] stale_results;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stale_results <= '0;
    else if (clear_pipe)
      stale_results <= stale_results + 16'(p_count);
    else if (int_rf_wr_en_wb && p_empty && (stale_results != 16'd0))
      stale_results <= stale_results - 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst && !clear_pipe)
      assert (!(int_rf_wr_en_wb && p_empty && (stale_results == 16'd0)))
        else $error("riscv_v_dispatch: v2i result with no pending destination");
  end
`endif

endmodule

// File: tb/tb_riscv_v_dispatch.sv
// Scoreboard bench: stimulus pushes expected issues/writebacks, a monitor pops and compares.
module tb_riscv_v_dispatch;
  import riscv_v_pkg::*;

`ifdef RISCV_V_DISPATCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_pipe, sc_v_valid, sc_is_v2i, sc_fence;
  logic [31:0] sc_instr, sc_rs1_data;
  logic [5:0]  sc_opcode;
  logic [4:0]  sc_rd_addr, sc_rs1_addr, sc_rs2_addr;
  logic        sc_stall;
  logic [31:0] instruction_id, int_rf_rd_data_id;
  logic [5:0]  opcode_id;
  logic        riscv_v_stall;
  logic [31:0] int_rf_wr_data_wb;
  logic        int_rf_wr_en_wb;
  logic        sc_rf_wr_en;
  logic [4:0]  sc_rf_wr_addr;
  logic [31:0] sc_rf_wr_data;

  riscv_v_dispatch dut (
    .clk(clk), .rst(rst), .clear_pipe(clear_pipe), .sc_v_valid(sc_v_valid),
    .sc_instr(sc_instr), .sc_opcode(sc_opcode), .sc_rs1_data(sc_rs1_data),
    .sc_is_v2i(sc_is_v2i), .sc_rd_addr(sc_rd_addr), .sc_fence(sc_fence),
    .sc_rs1_addr(sc_rs1_addr), .sc_rs2_addr(sc_rs2_addr), .sc_stall(sc_stall),
    .instruction_id(instruction_id), .opcode_id(opcode_id),
    .int_rf_rd_data_id(int_rf_rd_data_id), .riscv_v_stall(riscv_v_stall),
    .int_rf_wr_data_wb(int_rf_wr_data_wb), .int_rf_wr_en_wb(int_rf_wr_en_wb),
    .sc_rf_wr_en(sc_rf_wr_en), .sc_rf_wr_addr(sc_rf_wr_addr), .sc_rf_wr_data(sc_rf_wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [5:0] op; logic [31:0] instr; logic [31:0] data; } iss_t;
  typedef struct { logic [4:0] addr; logic [31:0] data; } wb_t;

  iss_t exp_iss[$];
  wb_t  exp_wb[$];
  int   iss_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;
  iss_t mon_i;
  wb_t  mon_w;

  always @(negedge clk) begin
    if (rst && opcode_id != RISCV_V_NOP_OPCODE && !riscv_v_stall) begin
      checks++;
      if (exp_iss.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got op=%0d instr=%h, required no issue", opcode_id, instruction_id);
      end else begin
        mon_i = exp_iss.pop_front();
        iss_cyc.push_back(cyc);
        if (opcode_id !== mon_i.op || instruction_id !== mon_i.instr || int_rf_rd_data_id !== mon_i.data) begin
          errors++;
          $display("FAIL issue: got op=%0d instr=%h data=%h, required op=%0d instr=%h data=%h",
                   opcode_id, instruction_id, int_rf_rd_data_id, mon_i.op, mon_i.instr, mon_i.data);
        end else
          $display("issue  cyc=%0d op=%0d instr=%h data=%h", cyc, opcode_id, instruction_id, int_rf_rd_data_id);
      end
    end
    if (rst && sc_rf_wr_en) begin
      checks++;
      wr_count++;
      if (exp_wb.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected: got addr=%0d data=%h, required no write", sc_rf_wr_addr, sc_rf_wr_data);
      end else begin
        mon_w = exp_wb.pop_front();
        if (sc_rf_wr_addr !== mon_w.addr || sc_rf_wr_data !== mon_w.data) begin
          errors++;
          $display("FAIL rf_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   sc_rf_wr_addr, sc_rf_wr_data, mon_w.addr, mon_w.data);
        end else
          $display("rfwr   cyc=%0d addr=%0d data=%h", cyc, sc_rf_wr_addr, sc_rf_wr_data);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drive one instruction and hold it until decode is not stalled (bounded).
  task automatic offer(input logic [5:0] op, input logic [31:0] instr, input logic [31:0] data,
                       input logic v2i, input logic [4:0] rd, input bit expect_issue,
                       output int drv_cyc);
    int waited = 0;
    @(posedge clk); #1;
    sc_v_valid = 1'b1; sc_opcode = op; sc_instr = instr; sc_rs1_data = data;
    sc_is_v2i = v2i; sc_rd_addr = rd;
    drv_cyc = cyc;
    @(negedge clk);
    while (sc_stall && waited < 40) begin
      @(posedge clk); #1;
      @(negedge clk);
      waited++;
    end
    if (sc_stall) begin
      checks++; errors++;
      $display("FAIL offer_timeout: got sc_stall=1 for op=%0d, required acceptance", op);
    end else if (expect_issue)
      exp_iss.push_back('{op, instr, data});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      sc_v_valid = 1'b0; sc_is_v2i = 1'b0; sc_fence = 1'b0;
      clear_pipe = 1'b0; int_rf_wr_en_wb = 1'b0;
    end
  endtask

  task automatic result(input logic [31:0] data, input logic [4:0] addr, input bit expect_write);
    @(posedge clk); #1;
    int_rf_wr_en_wb = 1'b1; int_rf_wr_data_wb = data;
    if (expect_write) exp_wb.push_back('{addr, data});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit, required self-termination");
    $fatal(1, "watchdog");
  end

  int d0;

  initial begin
    rst = 1'b0; clear_pipe = 1'b0; sc_v_valid = 1'b0; sc_is_v2i = 1'b0; sc_fence = 1'b0;
    sc_instr = '0; sc_opcode = '0; sc_rs1_data = '0; sc_rd_addr = '0;
    sc_rs1_addr = '0; sc_rs2_addr = '0; riscv_v_stall = 1'b1;
    int_rf_wr_data_wb = '0; int_rf_wr_en_wb = 1'b0;

    @(negedge clk);
    check("rst_opcode", 32'(opcode_id), 32'(RISCV_V_NOP_OPCODE));
    check("rst_instr", instruction_id, 32'h0);
    check("rst_rs1data", int_rf_rd_data_id, 32'h0);
    check("rst_wr_en", 32'(sc_rf_wr_en), 32'h0);
    check("rst_wr_addr", 32'(sc_rf_wr_addr), 32'h0);
    check("rst_wr_data", sc_rf_wr_data, 32'h0);
    check("rst_stall", 32'(sc_stall), 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // Reset mid-stream: three entries queued behind a stalled vector unit.
    offer(6'd9,  32'hC000_0009, 32'h9, 1'b0, 5'd0, 1'b0, d0);
    offer(6'd10, 32'hC000_000A, 32'hA, 1'b1, 5'd3, 1'b0, d0);
    offer(6'd11, 32'hC000_000B, 32'hB, 1'b0, 5'd0, 1'b0, d0);
    @(posedge clk); #1;
    sc_v_valid = 1'b0; sc_is_v2i = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("midrst_opcode", 32'(opcode_id), 32'(RISCV_V_NOP_OPCODE));
    check("midrst_stall", 32'(sc_stall), 32'h0);
    check("midrst_wr_en", 32'(sc_rf_wr_en), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1; riscv_v_stall = 1'b0; sc_rs1_addr = 5'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_queue_empty", 32'(opcode_id), 32'(RISCV_V_NOP_OPCODE));
    check("midrst_pending_empty", 32'(sc_stall), 32'h0);
    sc_rs1_addr = 5'd0;

    // Back-to-back issue and latency.
    iss_cyc.delete();
    offer(6'd1, 32'hA000_0001, 32'h0000_0100, 1'b0, 5'd0, 1'b1, d0);
    offer(6'd2, 32'hA000_0002, 32'h0000_0200, 1'b0, 5'd0, 1'b1, d0);
    offer(6'd3, 32'hA000_0003, 32'h0000_0300, 1'b0, 5'd0, 1'b1, d0);
    offer(6'd4, 32'hA000_0004, 32'h0000_0400, 1'b0, 5'd0, 1'b1, d0);
    d0 = d0 - 3;
    idle(5);
    check("b2b_count", iss_cyc.size(), 32'd4);
    if (iss_cyc.size() == 4) begin
      check("latency", iss_cyc[0] - d0, LAT);
      for (int k = 1; k < 4; k++) check("b2b_gap", iss_cyc[k] - iss_cyc[k-1], 32'd1);
    end

    // Backpressure: queue fills to QDEPTH, decode stalls, nothing lost.
    @(posedge clk); #1 riscv_v_stall = 1'b1;
    for (int k = 0; k < 4; k++)
      offer(6'(21 + k), 32'hB000_0015 + k, 32'h15 + k, 1'b0, 5'd0, 1'b1, d0);
    @(posedge clk); #1;
    sc_opcode = 6'd25; sc_instr = 32'hB000_0019;
    @(negedge clk);
    check("full_stall", 32'(sc_stall), 32'h1);
    @(posedge clk); #1;
    sc_v_valid = 1'b0; riscv_v_stall = 1'b0;
    offer(6'd25, 32'hB000_0019, 32'h19, 1'b0, 5'd0, 1'b1, d0);
    offer(6'd26, 32'hB000_001A, 32'h1A, 1'b0, 5'd0, 1'b1, d0);
    idle(8);
    check("bp_drained", exp_iss.size(), 32'd0);

    // v2i RAW hazard on rs1, then x0 exclusion and rs2 hazard.
    offer(6'd7, 32'hD000_0007, 32'h7, 1'b1, 5'd5, 1'b1, d0);
    @(posedge clk); #1;
    sc_v_valid = 1'b0; sc_is_v2i = 1'b0; sc_rs1_addr = 5'd5;
    @(negedge clk);
    check("raw_rs1", 32'(sc_stall), 32'h1);
    idle(2);
    @(negedge clk);
    check("raw_hold", 32'(sc_stall), 32'h1);
    result(32'hDEADBEEF, 5'd5, 1'b1);
    @(negedge clk);
    check("raw_pop_cycle", 32'(sc_stall), 32'h1);
    idle(1);
    @(negedge clk);
    check("raw_wb_en", 32'(sc_rf_wr_en), 32'h1);
    check("raw_cleared", 32'(sc_stall), 32'h0);
    sc_rs1_addr = 5'd0;

    offer(6'd8, 32'hD000_0008, 32'h8, 1'b1, 5'd0, 1'b1, d0);
    idle(1);
    @(negedge clk);
    check("x0_no_hazard", 32'(sc_stall), 32'h0);
    result(32'h0BAD_0000, 5'd0, 1'b1);
    idle(1);
    offer(6'd12, 32'hD000_000C, 32'hC, 1'b1, 5'd12, 1'b1, d0);
    @(posedge clk); #1;
    sc_v_valid = 1'b0; sc_is_v2i = 1'b0; sc_rs2_addr = 5'd12;
    @(negedge clk);
    check("raw_rs2", 32'(sc_stall), 32'h1);
    result(32'h0000_C0DE, 5'd12, 1'b1);
    idle(2);
    @(negedge clk);
    check("raw_rs2_cleared", 32'(sc_stall), 32'h0);
    sc_rs2_addr = 5'd0;

    // Fence with two v2i outstanding.
    offer(6'd13, 32'hE000_000D, 32'hD, 1'b1, 5'd6, 1'b1, d0);
    offer(6'd14, 32'hE000_000E, 32'hE, 1'b1, 5'd7, 1'b1, d0);
    @(posedge clk); #1;
    sc_v_valid = 1'b0; sc_is_v2i = 1'b0; sc_fence = 1'b1;
    idle(1);
    @(negedge clk);
    check("fence_drain", 32'(sc_stall), 32'h1);
    idle(3);
    @(negedge clk);
    check("fence_hold", 32'(sc_stall), 32'h1);
    result(32'h1111_1111, 5'd6, 1'b1);
    @(negedge clk);
    check("fence_one_left", 32'(sc_stall), 32'h1);
    result(32'h2222_2222, 5'd7, 1'b1);
    idle(1);
    @(negedge clk);
    check("fence_until_written", 32'(sc_stall), 32'h1);
    idle(1);
    @(negedge clk);
    check("fence_released", 32'(sc_stall), 32'h0);
    @(posedge clk); #1 sc_fence = 1'b1;
    idle(1);
    @(negedge clk);
    check("fence_empty_run", 32'(sc_stall), 32'h0);

    // Flush: three queued (one v2i pending), then a stale result must be ignored.
    @(posedge clk); #1 riscv_v_stall = 1'b1;
    offer(6'd30, 32'hF000_001E, 32'h1E, 1'b0, 5'd0, 1'b0, d0);
    offer(6'd31, 32'hF000_001F, 32'h1F, 1'b0, 5'd0, 1'b0, d0);
    offer(6'd32, 32'hF000_0020, 32'h20, 1'b1, 5'd9, 1'b0, d0);
    @(posedge clk); #1;
    sc_v_valid = 1'b0; sc_is_v2i = 1'b0; sc_rs1_addr = 5'd9;
    @(negedge clk);
    check("preflush_hazard", 32'(sc_stall), 32'h1);
    @(posedge clk); #1 clear_pipe = 1'b1;
    @(posedge clk); #1;
    clear_pipe = 1'b0; riscv_v_stall = 1'b0;
    @(negedge clk);
    check("flush_nop", 32'(opcode_id), 32'(RISCV_V_NOP_OPCODE));
    check("flush_pending_empty", 32'(sc_stall), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("flush_queue_empty", 32'(opcode_id), 32'(RISCV_V_NOP_OPCODE));
    d0 = wr_count;
    result(32'hFFFF_0000, 5'd9, 1'b0);
    idle(3);
    @(negedge clk);
    check("late_result_ignored", wr_count, d0);
    sc_rs1_addr = 5'd0;

    idle(4);
    check("iss_scoreboard_empty", exp_iss.size(), 32'd0);
    check("wb_scoreboard_empty", exp_wb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
